mem_port_arbiter: RTL and testbench

// Shares one fixed-latency backing memory port between the IF stage (instruction fetch) and the MEM stage (load/store).

---
 rtl/mem_port_arbiter_pkg.sv | 16 +
 rtl/mem_port_arbiter_timer.sv | 26 ++
 rtl/mem_port_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the IF/MEM memory-port arbiter: FSM states and port-owner codes.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2,
      ARB_RESP  = 2'd3
   } arb_state_e;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;

endpackage

// File: rtl/mem_port_arbiter_timer.sv
// Latency countdown for the backing-memory access: load, decrement to zero, flag zero.
module mem_wait_timer #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic         o_zero
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (reset)
         r_cnt <= '0;
      else if (i_load)
         r_cnt <= i_load_val;
      else if (i_dec && (r_cnt != '0))
         r_cnt <= r_cnt - W'(1);
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between fetch (IF) and load/store (MEM),
// one transaction at a time, with fetch-kill on branch flush and a data-burst fairness limit.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int MEM_LATENCY = 4,
   parameter int MAX_D_BURST = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   input  logic        i_kill,
   output logic        i_valid,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_valid,
   output logic [31:0] d_rdata,
   output logic        stall_if,
   output logic        stall_mem,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam int TW = $clog2(MEM_LATENCY) + 1;
   localparam int BW = (MAX_D_BURST < 1) ? 1 : $clog2(MAX_D_BURST + 1);
   localparam logic [TW-1:0] LOAD_VAL  = TW'(MEM_LATENCY - 1);
   localparam logic [BW-1:0] BURST_MAX = BW'(MAX_D_BURST);

   arb_state_e  r_state, w_next;
   owner_e      r_owner;
   logic        r_kill;
   logic [BW-1:0] r_burst;
   logic        r_we;
   logic [31:0] r_addr, r_wdata, r_i_rdata, r_d_rdata;
   logic        w_fetch_prio, w_grant_i, w_grant_d, w_zero, w_busy;

   // Fetch wins only when data is absent or has used up its burst allowance.
   assign w_fetch_prio = i_req && (!d_req || (r_burst == BURST_MAX));
   assign w_grant_i    = (r_state == ARB_IDLE) && w_fetch_prio;
   assign w_grant_d    = (r_state == ARB_IDLE) && d_req && !w_fetch_prio;

   mem_wait_timer #(.W(TW)) u_timer (
      .clk        (clk),
      .reset      (reset),
      .i_load     (r_state == ARB_ISSUE),
      .i_load_val (LOAD_VAL),
      .i_dec      (r_state == ARB_WAIT),
      .o_zero     (w_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= ARB_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ARB_IDLE:  if (i_req || d_req) w_next = ARB_ISSUE;
         ARB_ISSUE: w_next = ARB_WAIT;
         ARB_WAIT:  if (w_zero) w_next = ARB_RESP;
         ARB_RESP:  w_next = ARB_IDLE;
      endcase
   end

   always_comb begin
      w_busy    = (r_state != ARB_IDLE);
      mem_req   = (r_state == ARB_ISSUE);
      mem_we    = w_busy && r_we;
      mem_addr  = w_busy ? r_addr  : 32'd0;
      mem_wdata = w_busy ? r_wdata : 32'd0;
      i_valid   = (r_state == ARB_RESP) && (r_owner == OWN_I) && !r_kill && !i_kill;
      d_valid   = (r_state == ARB_RESP) && (r_owner == OWN_D);
      stall_if  = i_req && !i_valid;
      stall_mem = d_req && !d_valid;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_owner   <= OWN_I;
         r_kill    <= 1'b0;
         r_burst   <= '0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_i_rdata <= '0;
         r_d_rdata <= '0;
      end else begin
         if (w_grant_i || w_grant_d) begin
            r_owner <= w_grant_d ? OWN_D : OWN_I;
            r_we    <= w_grant_d && d_we;
            r_addr  <= w_grant_d ? d_addr : i_addr;
            r_wdata <= w_grant_d ? d_wdata : 32'd0;
            r_kill  <= 1'b0;
         end else if (i_kill && w_busy && (r_owner == OWN_I)) begin
            r_kill  <= 1'b1;
         end

         if (!i_req || w_grant_i)
            r_burst <= '0;
         else if (w_grant_d && (r_burst != BURST_MAX))
            r_burst <= r_burst + BW'(1);

         // Capture on the last wait cycle so rdata is already stable during RESP.
         if ((r_state == ARB_WAIT) && w_zero) begin
            if (r_owner == OWN_D)
               r_d_rdata <= r_we ? 32'd0 : mem_rdata;
            else if (!r_kill && !i_kill)
               r_i_rdata <= mem_rdata;
         end
      end
   end

   assign i_rdata = r_i_rdata;
   assign d_rdata = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scenario bench for mem_port_arbiter: fixed-latency memory model plus a response scoreboard.
module tb_mem_port_arbiter;

   localparam int LAT  = 4;
   localparam int MAXB = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req, i_kill, d_req, d_we;
   logic [31:0] i_addr, d_addr, d_wdata;
   logic        i_valid, d_valid, stall_if, stall_mem, mem_req, mem_we;
   logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

   typedef struct {
      bit          own_d;
      logic [31:0] data;
      int          cyc;
   } resp_t;

   resp_t       sb[$];
   resp_t       mon_e;
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          iss_cyc  = -100;
   logic [31:0] iss_addr = 32'd0;
   logic [31:0] last_i   = 32'd0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.MEM_LATENCY(LAT), .MAX_D_BURST(MAXB)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill), .i_valid(i_valid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_valid(d_valid), .d_rdata(d_rdata),
      .stall_if(stall_if), .stall_mem(stall_mem),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return (a == 32'h40) ? 32'h00500093 : {a[15:0] ^ 16'h5A5A, a[15:0]};
   endfunction

   // Memory model: data is valid only in the cycle exactly LAT after the command.
   assign mem_rdata = (cyc == iss_cyc + LAT) ? mem_f(iss_addr) : 32'hBAD0BAD0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_req) begin
         iss_cyc  <= cyc;
         iss_addr <= mem_addr;
      end
   end

   always @(negedge clk) begin
      if (i_valid || d_valid) begin
         n_checks++;
         if (i_valid && d_valid) begin
            n_fail++;
            $display("FAIL both_valid: cyc=%0d i_valid=1 d_valid=1, expected one at a time", cyc);
         end else if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_valid: cyc=%0d i_valid=%0b d_valid=%0b, expected none", cyc, i_valid, d_valid);
         end else begin
            mon_e = sb.pop_front();
            if ((d_valid != mon_e.own_d) || (cyc != mon_e.cyc) ||
                ((d_valid ? d_rdata : i_rdata) !== mon_e.data)) begin
               n_fail++;
               $display("FAIL response: got own_d=%0b cyc=%0d data=%h, expected own_d=%0b cyc=%0d data=%h",
                        d_valid, cyc, d_valid ? d_rdata : i_rdata, mon_e.own_d, mon_e.cyc, mon_e.data);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      int t0;
      reset = 1'b1;
      tick(); tick();
      @(negedge clk);
      n_checks++;
      if ({mem_req, mem_we, i_valid, d_valid, stall_if, stall_mem} !== 6'b0 || mem_addr !== 32'd0 ||
          mem_wdata !== 32'd0 || i_rdata !== 32'd0 || d_rdata !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: mem_req=%0b i_valid=%0b d_valid=%0b mem_addr=%h i_rdata=%h d_rdata=%h, expected all 0",
                  mem_req, i_valid, d_valid, mem_addr, i_rdata, d_rdata);
      end
      tick();
      reset = 1'b0;
      i_req = 1'b1; i_addr = 32'h60; t0 = cyc;
      for (int k = 0; k <= 12; k++) begin
         if (k == 3) begin reset = 1'b1; i_req = 1'b0; end
         if (k == 4) reset = 1'b0;
         if (k == 5) begin
            d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
            sb.push_back('{own_d: 1'b1, data: mem_f(32'h300), cyc: t0 + 11});
         end
         if (k == 12) d_req = 1'b0;
         @(negedge clk);
         if (k == 1) begin
            n_checks++;
            if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rst_pre_issue: mem_req=%0b, expected 1", mem_req); end
         end
         if (k == 4) begin
            n_checks++;
            if ({mem_req, i_valid, d_valid} !== 3'b0 || mem_addr !== 32'd0) begin
               n_fail++;
               $display("FAIL rst_mid_wait: mem_req=%0b i_valid=%0b d_valid=%0b mem_addr=%h, expected idle zeros",
                        mem_req, i_valid, d_valid, mem_addr);
            end
         end
         if (k == 6) begin
            n_checks++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin
               n_fail++;
               $display("FAIL rst_reissue: mem_req=%0b mem_addr=%h, expected 1 / 00000300", mem_req, mem_addr);
            end
         end
         tick();
      end
      n_checks++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL rst_pending: %0d responses outstanding, expected 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_fetch_latency();
      int t0;
      i_req = 1'b1; i_addr = 32'h40; t0 = cyc;
      sb.push_back('{own_d: 1'b0, data: 32'h00500093, cyc: t0 + 6});
      last_i = 32'h00500093;
      for (int k = 0; k <= 7; k++) begin
         if (k == 7) i_req = 1'b0;
         @(negedge clk);
         n_checks++;
         if (mem_req !== (k == 1)) begin n_fail++; $display("FAIL fetch_mem_req: cycle %0d mem_req=%0b, expected %0b", k, mem_req, k == 1); end
         n_checks++;
         if (stall_if !== (k <= 5)) begin n_fail++; $display("FAIL fetch_stall: cycle %0d stall_if=%0b, expected %0b", k, stall_if, k <= 5); end
         n_checks++;
         if (i_valid !== (k == 6)) begin n_fail++; $display("FAIL fetch_valid: cycle %0d i_valid=%0b, expected %0b", k, i_valid, k == 6); end
         if (k == 1) begin
            n_checks++;
            if (mem_addr !== 32'h40 || mem_we !== 1'b0) begin n_fail++; $display("FAIL fetch_addr: mem_addr=%h mem_we=%0b, expected 00000040 / 0", mem_addr, mem_we); end
         end
         tick();
      end
      n_checks++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL fetch_pending: %0d responses outstanding, expected 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_arbitration();
      int t0;
      i_req = 1'b1; i_addr = 32'h44; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; t0 = cyc;
      sb.push_back('{own_d: 1'b1, data: mem_f(32'h100), cyc: t0 + 6});
      sb.push_back('{own_d: 1'b0, data: mem_f(32'h44),  cyc: t0 + 13});
      last_i = mem_f(32'h44);
      for (int k = 0; k <= 14; k++) begin
         if (k == 7)  d_req = 1'b0;
         if (k == 14) i_req = 1'b0;
         @(negedge clk);
         if (k == 1) begin
            n_checks++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin n_fail++; $display("FAIL arb_first: mem_req=%0b mem_addr=%h, expected 1 / 00000100", mem_req, mem_addr); end
         end
         if (k == 8) begin
            n_checks++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h44) begin n_fail++; $display("FAIL arb_second: mem_req=%0b mem_addr=%h, expected 1 / 00000044", mem_req, mem_addr); end
         end
         tick();
      end
      n_checks++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL arb_pending: %0d responses outstanding, expected 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_burst();
      int t0;
      i_req = 1'b1; i_addr = 32'h48; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h180; t0 = cyc;
      for (int g = 0; g < MAXB; g++)
         sb.push_back('{own_d: 1'b1, data: mem_f(32'h180), cyc: t0 + 6 + 7 * g});
      sb.push_back('{own_d: 1'b0, data: mem_f(32'h48), cyc: t0 + 6 + 7 * MAXB});
      last_i = mem_f(32'h48);
      for (int k = 0; k <= 28; k++) begin
         if (k == 28) begin i_req = 1'b0; d_req = 1'b0; end
         @(negedge clk);
         if (k == 1 || k == 8 || k == 15) begin
            n_checks++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h180) begin n_fail++; $display("FAIL burst_data: cycle %0d mem_addr=%h, expected 00000180", k, mem_addr); end
         end
         if (k == 22) begin
            n_checks++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h48) begin n_fail++; $display("FAIL burst_forced_fetch: mem_req=%0b mem_addr=%h, expected 1 / 00000048", mem_req, mem_addr); end
         end
         tick();
      end
      n_checks++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL burst_pending: %0d responses outstanding, expected 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_kill();
      int t0;
      i_req = 1'b1; i_addr = 32'h80; t0 = cyc;
      for (int k = 0; k <= 14; k++) begin
         if (k == 3) begin i_kill = 1'b1; i_req = 1'b0; end
         if (k == 4) i_kill = 1'b0;
         if (k == 7) begin
            i_req = 1'b1; i_addr = 32'h84;
            sb.push_back('{own_d: 1'b0, data: mem_f(32'h84), cyc: t0 + 13});
         end
         if (k == 14) i_req = 1'b0;
         @(negedge clk);
         if (k == 1) begin
            n_checks++;
            if (mem_req !== 1'b1) begin n_fail++; $display("FAIL kill_issue: mem_req=%0b, expected 1", mem_req); end
         end
         if (k == 6) begin
            n_checks++;
            if (i_valid !== 1'b0 || i_rdata !== last_i) begin
               n_fail++;
               $display("FAIL kill_resp: i_valid=%0b i_rdata=%h, expected 0 / %h", i_valid, i_rdata, last_i);
            end
         end
         if (k == 7) begin
            n_checks++;
            if (mem_req !== 1'b0 || mem_addr !== 32'd0) begin n_fail++; $display("FAIL kill_idle: mem_req=%0b mem_addr=%h, expected 0 / 00000000", mem_req, mem_addr); end
         end
         if (k == 8) begin
            n_checks++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h84) begin n_fail++; $display("FAIL kill_refetch: mem_req=%0b mem_addr=%h, expected 1 / 00000084", mem_req, mem_addr); end
         end
         tick();
      end
      n_checks++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL kill_pending: %0d responses outstanding, expected 0", sb.size()); sb.delete(); end
      // Kill arriving in the response cycle itself.
      i_req = 1'b1; i_addr = 32'h88;
      for (int k = 0; k <= 7; k++) begin
         if (k == 6) i_kill = 1'b1;
         if (k == 7) begin i_kill = 1'b0; i_req = 1'b0; end
         @(negedge clk);
         if (k == 6) begin
            n_checks++;
            if (i_valid !== 1'b0) begin n_fail++; $display("FAIL kill_same_cycle: i_valid=%0b, expected 0", i_valid); end
         end
         tick();
      end
   endtask

   task automatic test_store();
      int t0;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF; t0 = cyc;
      sb.push_back('{own_d: 1'b1, data: 32'd0, cyc: t0 + 6});
      for (int k = 0; k <= 8; k++) begin
         if (k == 3) i_kill = 1'b1;
         if (k == 4) i_kill = 1'b0;
         if (k == 7) begin d_req = 1'b0; d_we = 1'b0; end
         @(negedge clk);
         if (k == 1) begin
            n_checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h200 || mem_wdata !== 32'hDEADBEEF) begin
               n_fail++;
               $display("FAIL store_cmd: mem_req=%0b mem_we=%0b mem_addr=%h mem_wdata=%h, expected 1 / 1 / 00000200 / deadbeef",
                        mem_req, mem_we, mem_addr, mem_wdata);
            end
         end
         if (k == 3) begin
            n_checks++;
            if (stall_mem !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'hDEADBEEF) begin
               n_fail++;
               $display("FAIL store_hold: stall_mem=%0b mem_we=%0b mem_wdata=%h, expected 1 / 1 / deadbeef", stall_mem, mem_we, mem_wdata);
            end
         end
         if (k == 6) begin
            n_checks++;
            if (d_valid !== 1'b1 || stall_mem !== 1'b0) begin n_fail++; $display("FAIL store_done: d_valid=%0b stall_mem=%0b, expected 1 / 0", d_valid, stall_mem); end
         end
         if (k == 7) begin
            n_checks++;
            if (mem_we !== 1'b0 || mem_wdata !== 32'd0 || mem_addr !== 32'd0) begin
               n_fail++;
               $display("FAIL store_idle: mem_we=%0b mem_addr=%h mem_wdata=%h, expected zeros", mem_we, mem_addr, mem_wdata);
            end
         end
         tick();
      end
      n_checks++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL store_pending: %0d responses outstanding, expected 0", sb.size()); sb.delete(); end
   endtask

   initial begin
      reset = 1'b1; i_req = 1'b0; i_kill = 1'b0; d_req = 1'b0; d_we = 1'b0;
      i_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0;
      test_reset();
      test_fetch_latency();
      test_arbitration();
      test_burst();
      test_kill();
      test_store();
      tick(); tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
